oam_dma_master: RTL and testbench

// Bus initiator that copies 160 bytes from {SRC_HI,8'h00}.. into OAM at 16'hFE00..FE9F, the write
// end of the sprite-attribute path the LCD peripheral responds to. CPU starts it by writing 16'hFF46.

---
 rtl/oam_dma_master.sv | 151 +++++++++++++++
 tb/tb_oam_dma_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_master.sv
// oam_dma_master: copies XFER_LEN bytes from {src_hi,8'h00} into OAM.
// Started or restarted by a CPU write to DMA_REG_ADDR. Each byte takes
// three granted cycles: a read issue, a read-data capture, then an OAM write.
module oam_dma_master #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_addr,
  input  logic        s_wr,
  input  logic        s_rd,
  input  logic [7:0]  s_wdata,
  output logic [7:0]  s_rdata,
  output logic        s_rvalid,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [7:0]  m_rdata,
  output logic [7:0]  m_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  localparam logic [7:0] LEN8      = 8'(XFER_LEN);
  localparam logic [7:0] ECHO_BASE = 8'hE0;
  localparam logic [7:0] ECHO_OFFS = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q;      // value as written, used for readback
  logic [7:0] src_eff_q;  // echo-remapped source page
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  logic        reg_hit;
  logic        cpu_start;
  logic [7:0]  src_eff_in;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;

  // Slave-side decode and echo remap of the written source page
  always_comb begin
    reg_hit    = (s_addr == DMA_REG_ADDR);
    cpu_start  = s_wr && reg_hit;
    src_eff_in = (s_wdata >= ECHO_BASE) ? 8'(s_wdata - ECHO_OFFS) : s_wdata;
    rd_addr    = {src_eff_q, 8'h00} + {8'h00, idx_q};
    wr_addr    = OAM_BASE + {8'h00, idx_q};
  end

  // State, index, captured byte, source register and readback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      src_q     <= 8'h00;
      src_eff_q <= 8'h00;
      s_rvalid  <= 1'b0;
      s_rdata   <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      if (cpu_start) begin
        src_q     <= s_wdata;
        src_eff_q <= src_eff_in;
      end
      s_rvalid <= s_rd && reg_hit;
      s_rdata  <= (s_rd && reg_hit) ? src_q : 8'h00;
    end
  end

  // Next-state and master-bus outputs; strobes are gated by the grant
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    bus_req    = 1'b0;
    m_addr     = 16'h0000;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_wdata    = 8'h00;
    dma_done   = 1'b0;
    dma_active = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = S_RD0;
      end
      S_RD0: begin
        bus_req = 1'b1;
        m_addr  = rd_addr;
        m_rd    = bus_gnt;
        if (bus_gnt) state_d = S_RD1;
      end
      S_RD1: begin
        bus_req = 1'b1;
        m_addr  = rd_addr;
        m_rd    = bus_gnt;
        if (bus_gnt) begin
          data_d  = m_rdata;
          state_d = S_WR;
        end else begin
          // Responder's registered data may be stale; replay the read
          state_d = S_RD0;
        end
      end
      S_WR: begin
        bus_req = 1'b1;
        m_addr  = wr_addr;
        m_wdata = data_q;
        m_wr    = bus_gnt;
        if (bus_gnt) begin
          idx_d   = 8'(idx_q + 8'd1);
          state_d = (8'(idx_q + 8'd1) == LEN8) ? S_FIN : S_RD0;
        end
      end
      S_FIN: begin
        dma_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A CPU start overrides whatever the engine was doing
    if (cpu_start) begin
      state_d = S_REQ;
      idx_d   = 8'h00;
      data_d  = 8'h00;
    end
  end

endmodule

// File: tb/tb_oam_dma_master.sv
// Testbench for oam_dma_master: memory/OAM responder model plus scenario tasks.
module tb_oam_dma_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_addr;
  logic        s_wr, s_rd;
  logic [7:0]  s_wdata, s_rdata;
  logic        s_rvalid, bus_req, bus_gnt;
  logic [15:0] m_addr;
  logic        m_rd, m_wr;
  logic [7:0]  m_rdata, m_wdata;
  logic        dma_active, dma_done;

  oam_dma_master dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .s_wr(s_wr), .s_rd(s_rd),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .m_addr(m_addr), .m_rd(m_rd),
    .m_wr(m_wr), .m_rdata(m_rdata), .m_wdata(m_wdata),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] oam_got [0:159];
  logic [7:0] exp_src = 8'h00;
  int wr_cnt, bad_wr_cnt, rd_bad, done_cnt, done_cyc;
  int overlap_err = 0, self_hit = 0, nogrant_err = 0;

  // Bus responder: registered read data, OAM capture, protocol monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_rd) begin
      m_rdata <= mem[m_addr];
      if (m_addr[15:8] !== exp_src || m_addr[7:0] >= 8'd160) rd_bad++;
    end
    if (m_wr) begin
      wr_cnt++;
      if (m_addr >= 16'hFE00 && m_addr < 16'hFEA0) oam_got[8'(m_addr - 16'hFE00)] = m_wdata;
      else bad_wr_cnt++;
    end
    if (m_rd && m_wr) overlap_err++;
    if ((m_rd || m_wr) && !bus_gnt) nogrant_err++;
    if ((m_rd || m_wr) && m_addr == 16'hFF46) self_hit++;
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cnt = 0; bad_wr_cnt = 0; rd_bad = 0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 160; i++) oam_got[i] = 8'hxx;
  endtask

  function automatic logic [7:0] eff_page(input logic [7:0] v);
    return (v >= 8'hE0) ? 8'(v - 8'h20) : v;
  endfunction

  // Drives a one-cycle register write in the current cycle; wcyc is that cycle
  task automatic cpu_write(input logic [7:0] v, output int wcyc);
    s_addr = 16'hFF46; s_wdata = v; s_wr = 1'b1;
    wcyc = cyc;
    tick();
    s_wr = 1'b0; s_addr = 16'h0000;
    exp_src = eff_page(v);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    int lim;
    lim = cyc + budget;
    while (done_cnt == 0 && cyc < lim) tick();
    if (done_cnt == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: dma_done not seen within %0d cycles", name, budget);
    end
    tick();
  endtask

  task automatic check_oam(input string name);
    for (int i = 0; i < 160; i++) begin
      logic [7:0] e;
      e = mem[{exp_src, 8'(i)}];
      n_checks++;
      if (oam_got[i] !== e) begin
        n_fail++;
        $display("FAIL %s oam[%0d]: got %h expected %h", name, i, oam_got[i], e);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus_req, m_rd, m_wr, dma_active, dma_done, s_rvalid} !== 6'b0 ||
        m_addr !== 16'h0 || m_wdata !== 8'h0 || s_rdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b rd=%b wr=%b act=%b done=%b rv=%b addr=%h wd=%h rdat=%h expected all 0",
               bus_req, m_rd, m_wr, dma_active, dma_done, s_rvalid, m_addr, m_wdata, s_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int w;
    clear_log();
    bus_gnt = 1'b1;
    cpu_write(8'hC0, w);
    n_checks++;
    if (dma_active !== 1'b1 || bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start: active=%b req=%b expected 1 1", dma_active, bus_req);
    end
    wait_done("basic", 700);
    check_int("basic_latency", done_cyc - w, 482);
    check_int("basic_done_count", done_cnt, 1);
    check_int("basic_write_count", wr_cnt, 160);
    check_int("basic_bad_writes", bad_wr_cnt, 0);
    check_int("basic_bad_reads", rd_bad, 0);
    check_int("basic_active_after", int'(dma_active), 0);
    check_oam("basic");
  endtask

  task automatic test_pattern80();
    int w;
    clear_log();
    cpu_write(8'h80, w);
    wait_done("pattern80", 700);
    for (int i = 0; i < 160; i++) begin
      logic [7:0] e;
      e = 8'h5A ^ 8'(i);
      n_checks++;
      if (oam_got[i] !== e) begin
        n_fail++;
        $display("FAIL pattern80 oam[%0d]: got %h expected %h", i, oam_got[i], e);
      end
    end
    check_int("pattern80_no_fea0", bad_wr_cnt, 0);
  endtask

  // Byte i: RD0 at w+2+3i, RD1 at w+3+3i, WR at w+4+3i when always granted.
  // Losing RD1 replays RD0 (+1 cycle beyond the outage); a held WR costs only the outage.
  task automatic test_grant_loss();
    int w;
    int k;
    clear_log();
    bus_gnt = 1'b1;
    cpu_write(8'hC0, w);
    while (done_cnt == 0 && cyc < w + 800) begin
      k = cyc;
      bus_gnt = !((k >= w + 114 && k <= w + 118) || (k >= w + 280 && k <= w + 284));
      tick();
    end
    bus_gnt = 1'b1;
    tick();
    check_int("grant_loss_latency", done_cyc - w, 482 + 6 + 5);
    check_int("grant_loss_writes", wr_cnt, 160);
    check_int("grant_loss_bad_reads", rd_bad, 0);
    check_oam("grant_loss");
  endtask

  task automatic test_restart();
    int w, w2;
    clear_log();
    bus_gnt = 1'b1;
    cpu_write(8'hC0, w);
    wait_until(w + 152);
    cpu_write(8'hC1, w2);
    check_int("restart_active", int'(dma_active), 1);
    wait_done("restart", 700);
    check_int("restart_done_count", done_cnt, 1);
    check_int("restart_latency", done_cyc - w2, 482);
    check_int("restart_writes", wr_cnt, 50 + 160);
    check_int("restart_bad_reads", rd_bad, 0);
    check_oam("restart");
  endtask

  task automatic test_echo_readback();
    int w;
    clear_log();
    cpu_write(8'hF0, w);
    wait_done("echo", 700);
    check_int("echo_bad_reads", rd_bad, 0);
    check_oam("echo");
    s_addr = 16'hFF46; s_rd = 1'b1;
    n_checks++;
    if (s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_early: s_rvalid=%b expected 0", s_rvalid);
    end
    tick();
    s_rd = 1'b0; s_addr = 16'h0000;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 8'hF0) begin
      n_fail++;
      $display("FAIL readback: rvalid=%b rdata=%h expected 1 f0", s_rvalid, s_rdata);
    end
    tick();
    check_int("readback_drop", int'(s_rvalid), 0);
    s_addr = 16'hFF47; s_rd = 1'b1;
    tick();
    s_rd = 1'b0; s_addr = 16'h0000;
    check_int("readback_miss", int'(s_rvalid), 0);
  endtask

  task automatic test_reset_midrun();
    int w;
    clear_log();
    bus_gnt = 1'b1;
    cpu_write(8'hC0, w);
    wait_until(w + 32);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus_req, m_rd, m_wr, dma_active, dma_done} !== 5'b0 || m_addr !== 16'h0 || m_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: req=%b rd=%b wr=%b act=%b done=%b addr=%h expected all 0",
               bus_req, m_rd, m_wr, dma_active, dma_done, m_addr);
    end
    reset = 1'b0;
    repeat (30) tick();
    check_int("midrun_writes", wr_cnt, 10);
    check_int("midrun_no_done", done_cnt, 0);
    check_int("midrun_idle", int'(dma_active), 0);
    s_addr = 16'hFF46; s_rd = 1'b1;
    tick();
    s_rd = 1'b0; s_addr = 16'h0000;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_src_cleared: rvalid=%b rdata=%h expected 1 00", s_rvalid, s_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int w;
      logic [7:0] src;
      clear_log();
      src = 8'($urandom_range(0, 255));
      bus_gnt = 1'b1;
      cpu_write(src, w);
      while (done_cnt == 0 && cyc < w + 4000) begin
        bus_gnt = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus_gnt = 1'b1;
      tick();
      check_int("random_done_count", done_cnt, 1);
      check_int("random_writes", wr_cnt, 160);
      check_int("random_bad_reads", rd_bad, 0);
      check_int("random_bad_writes", bad_wr_cnt, 0);
      check_oam("random");
    end
  endtask

  initial begin
    reset = 1'b1; s_addr = 16'h0; s_wr = 1'b0; s_rd = 1'b0; s_wdata = 8'h0;
    bus_gnt = 1'b1; m_rdata = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h8000 + 16'(i)] = 8'(i) ^ 8'h5A;
    clear_log();

    test_reset();
    test_basic();
    test_pattern80();
    test_grant_loss();
    test_restart();
    test_echo_readback();
    test_reset_midrun();
    test_random();

    check_int("strobe_overlap", overlap_err, 0);
    check_int("strobe_without_grant", nogrant_err, 0);
    check_int("self_register_access", self_hit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
